// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: 100 Hz tick divider feeding a cascaded
// centisecond / second / minute / hour counter with rollover pulse.
module stopwatch_dp #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned MSEC_MAX = 100,
  parameter int unsigned SEC_MAX  = 60,
  parameter int unsigned MIN_MAX  = 60,
  parameter int unsigned HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_runstop,
  input  logic       i_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick,
  output logic       o_wrap
);

  localparam int unsigned DIV_W  = $clog2(TICK_DIV);
  localparam int unsigned MSEC_W = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [MSEC_W-1:0] msec_q, msec_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;

  logic div_end_c, msec_end_c, sec_end_c, min_end_c, hour_end_c;

  assign div_end_c  = (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign msec_end_c = (msec_q == MSEC_W'(MSEC_MAX - 1));
  assign sec_end_c  = (sec_q == SEC_W'(SEC_MAX - 1));
  assign min_end_c  = (min_q == MIN_W'(MIN_MAX - 1));
  assign hour_end_c = (hour_q == HOUR_W'(HOUR_MAX - 1));

  // Next state: clear beats run beats hold; all carries ripple on the tick edge.
  always_comb begin
    div_cnt_d = div_cnt_q;
    msec_d    = msec_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;

    if (i_clear) begin
      div_cnt_d = '0;
      msec_d    = '0;
      sec_d     = '0;
      min_d     = '0;
      hour_d    = '0;
    end else if (i_runstop) begin
      if (!div_end_c) begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end else begin
        div_cnt_d = '0;
        tick_d    = 1'b1;
        if (!msec_end_c) begin
          msec_d = msec_q + MSEC_W'(1);
        end else begin
          msec_d = '0;
          if (!sec_end_c) begin
            sec_d = sec_q + SEC_W'(1);
          end else begin
            sec_d = '0;
            if (!min_end_c) begin
              min_d = min_q + MIN_W'(1);
            end else begin
              min_d = '0;
              if (!hour_end_c) begin
                hour_d = hour_q + HOUR_W'(1);
              end else begin
                hour_d = '0;
                wrap_d = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign o_msec = msec_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hour_q;
  assign o_tick = tick_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Scoreboard bench for stopwatch_dp: a full-size instance and a small-modulus
// instance (so the 23:59:59.99-style rollover is reached quickly) share inputs.
module tb_stopwatch_dp;

  typedef struct packed {
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic clk, rst, i_runstop, i_clear;
  logic [6:0] msec0, msec1;
  logic [5:0] sec0, sec1, min0, min1;
  logic [4:0] hour0, hour1;
  logic tick0, tick1, wrap0, wrap1;

  stopwatch_dp #(.TICK_DIV(4), .MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24)) u_dut0 (
    .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear),
    .o_msec(msec0), .o_sec(sec0), .o_min(min0), .o_hour(hour0),
    .o_tick(tick0), .o_wrap(wrap0)
  );

  stopwatch_dp #(.TICK_DIV(3), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)) u_dut1 (
    .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear),
    .o_msec(msec1), .o_sec(sec1), .o_min(min1), .o_hour(hour1),
    .o_tick(tick1), .o_wrap(wrap1)
  );

  // Reference model: a divider phase and a total centisecond count per instance.
  int div_p  [2] = '{4, 3};
  int msec_m [2] = '{100, 4};
  int sec_m  [2] = '{60, 3};
  int min_m  [2] = '{60, 3};
  int hour_m [2] = '{24, 2};
  int ph [2];
  int cs [2];

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int miscompares = 0;
  int tick_cnt [2] = '{0, 0};
  int wrap_cnt [2] = '{0, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t sample(input int k);
    exp_t a;
    if (k == 0) a = '{msec: msec0, sec: sec0, min: min0, hour: hour0, tick: tick0, wrap: wrap0};
    else        a = '{msec: msec1, sec: sec1, min: min1, hour: hour1, tick: tick1, wrap: wrap1};
    return a;
  endfunction

  task automatic check(input string name, input int k, input exp_t e, input exp_t a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %0d:%0d:%0d.%0d tick=%0b wrap=%0b, expected %0d:%0d:%0d.%0d tick=%0b wrap=%0b",
               name, k, $time, a.hour, a.min, a.sec, a.msec, a.tick, a.wrap,
               e.hour, e.min, e.sec, e.msec, e.tick, e.wrap);
    end
  endtask

  task automatic model_step(input logic r, input logic run, input logic clr);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int period;
      period = msec_m[k] * sec_m[k] * min_m[k] * hour_m[k];
      e = '0;
      if (!r || clr) begin
        ph[k] = 0;
        cs[k] = 0;
      end else if (run) begin
        ph[k]++;
        if (ph[k] == div_p[k]) begin
          ph[k] = 0;
          cs[k] = (cs[k] + 1) % period;
          e.tick = 1'b1;
          e.wrap = (cs[k] == 0);
        end
      end
      e.msec = 7'(cs[k] % msec_m[k]);
      e.sec  = 6'((cs[k] / msec_m[k]) % sec_m[k]);
      e.min  = 6'((cs[k] / (msec_m[k] * sec_m[k])) % min_m[k]);
      e.hour = 5'(cs[k] / (msec_m[k] * sec_m[k] * min_m[k]));
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic run, input logic clr);
    @(negedge clk);
    rst = r;
    i_runstop = run;
    i_clear = clr;
    model_step(r, run, clr);
  endtask

  task automatic step_n(input int n, input logic r, input logic run, input logic clr);
    for (int i = 0; i < n; i++) step(r, run, clr);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, expected 0", q0.size(), q1.size());
    end
  endtask

  // Monitor: outputs are valid every cycle; compare one cycle after each edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        a = sample(0);
        check("cycle", 0, e, a);
        if (a.tick) tick_cnt[0]++;
        if (a.wrap) wrap_cnt[0]++;
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        a = sample(1);
        check("cycle", 1, e, a);
        if (a.tick) tick_cnt[1]++;
        if (a.wrap) wrap_cnt[1]++;
      end
    end
  end

  initial begin
    int t0, w0, w1;
    exp_t z;
    z = '0;
    rst = 1'b0;
    i_runstop = 1'b1;
    i_clear = 1'b0;

    // Reset held with run high, then first tick on 4th edge after release.
    step_n(3, 1'b0, 1'b1, 1'b0);
    step_n(6, 1'b1, 1'b1, 1'b0);

    // 400 edges from clear: 1.00 s and 100 ticks, no wrap.
    step(1'b1, 1'b0, 1'b1);
    drain();
    t0 = tick_cnt[0];
    w0 = wrap_cnt[0];
    step_n(400, 1'b1, 1'b1, 1'b0);
    drain();
    vectors++;
    if (tick_cnt[0] - t0 != 100 || wrap_cnt[0] != w0) begin
      miscompares++;
      $display("FAIL tick_count: got %0d ticks %0d wraps, expected 100 ticks 0 wraps",
               tick_cnt[0] - t0, wrap_cnt[0] - w0);
    end

    // Stop/resume keeps the divider phase.
    step(1'b1, 1'b0, 1'b1);
    step_n(6, 1'b1, 1'b1, 1'b0);
    step_n(50, 1'b1, 1'b0, 1'b0);
    step_n(2, 1'b1, 1'b1, 1'b0);

    // Clear priority at div_cnt==3, then first tick 4 edges after clear drops.
    step(1'b1, 1'b0, 1'b1);
    step_n(3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step_n(5, 1'b1, 1'b1, 1'b0);

    // Cascade up to 00:01:00.00; the small instance wraps many times meanwhile.
    step(1'b1, 1'b0, 1'b1);
    w1 = wrap_cnt[1];
    step_n(24000, 1'b1, 1'b1, 1'b0);
    drain();
    vectors++;
    if (wrap_cnt[1] - w1 != 24000 / (3 * 72)) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d, expected %0d", wrap_cnt[1] - w1, 24000 / (3 * 72));
    end

    // Run to 00:00:12.34 then assert reset asynchronously mid-cycle.
    step(1'b1, 1'b0, 1'b1);
    step_n(1234 * 4, 1'b1, 1'b1, 1'b0);
    drain();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0;
      cs[k] = 0;
    end
    #1;
    check("async_reset", 0, z, sample(0));
    check("async_reset", 1, z, sample(1));
    step_n(2, 1'b0, 1'b1, 1'b0);
    step_n(5, 1'b1, 1'b0, 1'b0);
    step_n(8, 1'b1, 1'b1, 1'b0);

    // Randomised control mix with rare resets and clears.
    for (int i = 0; i < 3000; i++) begin
      int rr;
      rr = int'($urandom_range(199, 0));
      if (rr == 0)      step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      else if (rr < 5)  step(1'b1, 1'($urandom_range(1, 0)), 1'b1);
      else if (rr < 150) step(1'b1, 1'b1, 1'b0);
      else              step(1'b1, 1'b0, 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
